// File: rtl/mem_access_unit.sv
// Load/store adapter between EX/MEM and a word-only data memory.
// Extracts and extends load lanes; sub-word stores use a 2-cycle read-modify-write.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEn,
    output logic        MemReadEn,
    input  logic [31:0] MemReadData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AlignErr
);

    typedef enum logic [0:0] {StIdle, StRmwWr} fsmState_e;

    fsmState_e   state;
    logic [31:0] addrQ;
    logic [31:0] mergedQ;
    logic        alignErrQ;

    logic        isByte, isHalf, isWord, misaligned, subStore;
    logic [1:0]  laneByte;
    logic        laneHalf;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] loadVal;
    logic [31:0] merged;

    always_comb begin
        isByte     = (Size == 2'b00);
        isHalf     = (Size == 2'b01);
        isWord     = Size[1];
        misaligned = (isHalf && Address[0]) || (isWord && (Address[1:0] != 2'b00));
        laneByte   = BIG_ENDIAN ? ~Address[1:0] : Address[1:0];
        laneHalf   = BIG_ENDIAN ? ~Address[1] : Address[1];
        subStore   = Rst_n && (state == StIdle) && MemWrite && !misaligned && !isWord;

        unique case (laneByte)
            2'd0:    byteVal = MemReadData[7:0];
            2'd1:    byteVal = MemReadData[15:8];
            2'd2:    byteVal = MemReadData[23:16];
            default: byteVal = MemReadData[31:24];
        endcase
        halfVal = laneHalf ? MemReadData[31:16] : MemReadData[15:0];

        if (isByte) begin
            loadVal = {{24{!Unsigned && byteVal[7]}}, byteVal};
        end else if (isHalf) begin
            loadVal = {{16{!Unsigned && halfVal[15]}}, halfVal};
        end else begin
            loadVal = MemReadData;
        end

        merged = MemReadData;
        if (isByte) begin
            unique case (laneByte)
                2'd0:    merged[7:0]   = WriteData[7:0];
                2'd1:    merged[15:8]  = WriteData[7:0];
                2'd2:    merged[23:16] = WriteData[7:0];
                default: merged[31:24] = WriteData[7:0];
            endcase
        end else if (laneHalf) begin
            merged[31:16] = WriteData[15:0];
        end else begin
            merged[15:0] = WriteData[15:0];
        end
    end

    // Reset gates every enable so a pending RMW write is dropped immediately.
    always_comb begin
        MemAddress   = {Address[31:2], 2'b00};
        MemWriteData = WriteData;
        MemWriteEn   = 1'b0;
        MemReadEn    = 1'b0;
        ReadData     = 32'h0;
        Stall        = 1'b0;
        if (!Rst_n) begin
            MemWriteEn = 1'b0;
        end else if (state == StRmwWr) begin
            MemAddress   = addrQ;
            MemWriteData = mergedQ;
            MemWriteEn   = 1'b1;
        end else if (MemWrite && !misaligned) begin
            if (isWord) begin
                MemWriteEn = 1'b1;
            end else begin
                MemReadEn = 1'b1;
                Stall     = 1'b1;
            end
        end else if (MemRead && !MemWrite && !misaligned) begin
            MemReadEn = 1'b1;
            ReadData  = loadVal;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= StIdle;
            addrQ     <= 32'h0;
            mergedQ   <= 32'h0;
            alignErrQ <= 1'b0;
        end else begin
            alignErrQ <= (state == StIdle) && (MemRead || MemWrite) && misaligned;
            unique case (state)
                StIdle: begin
                    if (subStore) begin
                        state   <= StRmwWr;
                        addrQ   <= {Address[31:2], 2'b00};
                        mergedQ <= merged;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign AlignErr = alignErrQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-wide memory model.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic [31:0] Address, WriteData, MemAddress, MemWriteData, MemReadData, ReadData;
    logic        MemRead, MemWrite, Unsigned, MemWriteEn, MemReadEn, Stall, AlignErr;
    logic [1:0]  Size;
    logic        preload;
    logic [31:0] mem [0:63];

    int nChecks = 0;
    int nFails  = 0;

    always #5 Clk = ~Clk;

    mem_access_unit #(.BIG_ENDIAN(1'b0)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Size         (Size),
        .Unsigned     (Unsigned),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWriteEn   (MemWriteEn),
        .MemReadEn    (MemReadEn),
        .MemReadData  (MemReadData),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .AlignErr     (AlignErr)
    );

    assign MemReadData = mem[MemAddress[7:2]];

    always @(posedge Clk) begin
        if (preload) begin
            mem[4] <= 32'h8899AABB;
        end else if (MemWriteEn) begin
            mem[MemAddress[7:2]] <= MemWriteData;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        MemRead   = rd;
        MemWrite  = wr;
        Size      = sz;
        Unsigned  = uns;
        Address   = addr;
        WriteData = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic preloadMem();
        idle();
        step();
        preload = 1'b1;
        step();
        preload = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        preload = 1'b0;
        Rst_n   = 1'b0;
        idle();
        @(negedge Clk);
        checkVal("rst_stall", 32'(Stall), 32'h0);
        checkVal("rst_wen", 32'(MemWriteEn), 32'h0);
        checkVal("rst_ren", 32'(MemReadEn), 32'h0);
        checkVal("rst_rdata", ReadData, 32'h0);
        checkVal("rst_alignerr", 32'(AlignErr), 32'h0);
        step();
        Rst_n = 1'b1;
        preloadMem();

        // 1: byte loads
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        @(negedge Clk);
        checkVal("lb_0x11", ReadData, 32'hFFFFFFAA);
        checkVal("lb_stall", 32'(Stall), 32'h0);
        checkVal("lb_ren", 32'(MemReadEn), 32'h1);
        step();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        @(negedge Clk);
        checkVal("lbu_0x11", ReadData, 32'h000000AA);

        // 2: half and word loads
        step();
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        @(negedge Clk);
        checkVal("lh_0x12", ReadData, 32'hFFFF8899);
        step();
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        @(negedge Clk);
        checkVal("lhu_0x12", ReadData, 32'h00008899);
        step();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(negedge Clk);
        checkVal("lw_0x10", ReadData, 32'h8899AABB);
        checkVal("lw_addr", MemAddress, 32'h10);

        // 3: sb read-modify-write
        preloadMem();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h55);
        @(negedge Clk);
        checkVal("sb_c1_stall", 32'(Stall), 32'h1);
        checkVal("sb_c1_wen", 32'(MemWriteEn), 32'h0);
        checkVal("sb_c1_ren", 32'(MemReadEn), 32'h1);
        step();
        @(negedge Clk);
        checkVal("sb_c2_stall", 32'(Stall), 32'h0);
        checkVal("sb_c2_wen", 32'(MemWriteEn), 32'h1);
        checkVal("sb_c2_wdata", MemWriteData, 32'h8855AABB);
        step();
        idle();
        @(negedge Clk);
        checkVal("sb_c3_wen", 32'(MemWriteEn), 32'h0);
        checkVal("sb_mem", mem[4], 32'h8855AABB);

        // 4: back-to-back sh then sb
        preloadMem();
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234);
        @(negedge Clk);
        checkVal("b2b_stall0", 32'(Stall), 32'h1);
        step();
        @(negedge Clk);
        checkVal("b2b_stall1", 32'(Stall), 32'h0);
        step();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h77);
        @(negedge Clk);
        checkVal("b2b_stall2", 32'(Stall), 32'h1);
        step();
        @(negedge Clk);
        checkVal("b2b_stall3", 32'(Stall), 32'h0);
        step();
        idle();
        @(negedge Clk);
        checkVal("b2b_mem", mem[4], 32'h77991234);

        // 5: misaligned accesses
        preloadMem();
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        @(negedge Clk);
        checkVal("lw_mis_rdata", ReadData, 32'h0);
        checkVal("lw_mis_err_now", 32'(AlignErr), 32'h0);
        step();
        idle();
        @(negedge Clk);
        checkVal("lw_mis_err_next", 32'(AlignErr), 32'h1);
        step();
        @(negedge Clk);
        checkVal("lw_mis_err_after", 32'(AlignErr), 32'h0);
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'hCAFE);
        #1;
        checkVal("sh_mis_wen", 32'(MemWriteEn), 32'h0);
        checkVal("sh_mis_stall", 32'(Stall), 32'h0);
        step();
        idle();
        @(negedge Clk);
        checkVal("sh_mis_err", 32'(AlignErr), 32'h1);
        checkVal("sh_mis_mem", mem[4], 32'h8899AABB);

        // 6: reset during RMW_WR drops the pending write
        preloadMem();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hEE);
        @(negedge Clk);
        checkVal("rst_rmw_stall", 32'(Stall), 32'h1);
        step();
        @(negedge Clk);
        checkVal("rst_rmw_wen_pre", 32'(MemWriteEn), 32'h1);
        #1 Rst_n = 1'b0;
        #1;
        checkVal("rst_rmw_wen_drop", 32'(MemWriteEn), 32'h0);
        checkVal("rst_rmw_stall_rst", 32'(Stall), 32'h0);
        step();
        idle();
        Rst_n = 1'b1;
        @(negedge Clk);
        checkVal("rst_rmw_mem", mem[4], 32'h8899AABB);
        checkVal("rst_rmw_wen_idle", 32'(MemWriteEn), 32'h0);
        step();
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hEE);
        @(negedge Clk);
        checkVal("rst_rmw_idle_stall", 32'(Stall), 32'h1);
        step();
        idle();
        step();
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        @(negedge Clk);
        checkVal("post_rst_lbu", ReadData, 32'h000000EE);

        step();
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
